// File: rtl/dram_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dram_cmd_sched
//  Purpose  : Open-page DDR4 command scheduler. Turns one request at a time
//             into a timed PRE/ACT/RD/WR sequence over 16 tracked banks.
//  Revision : 1.0  initial release
// ============================================================================
module dram_cmd_sched #(
    parameter int unsigned T_RCD   = 24,
    parameter int unsigned T_RP    = 24,
    parameter int unsigned T_RAS   = 52,
    parameter int unsigned T_CL    = 24,
    parameter int unsigned T_CWL   = 20,
    parameter int unsigned T_BURST = 4,
    parameter int unsigned T_WR    = 20,
    parameter int unsigned T_RTP   = 12
) (
    input  logic        CPU_clock,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_opcode,
    input  logic [32:0] req_addr,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [1:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [14:0] cmd_row,
    output logic [10:0] cmd_col,
    output logic [63:0] dram_cycle,
    output logic        req_done,
    output logic [1:0]  hit_type
);
    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    localparam logic [1:0] HT_HIT      = 2'd0;
    localparam logic [1:0] HT_MISS     = 2'd1;
    localparam logic [1:0] HT_CONFLICT = 2'd2;

    localparam logic [1:0] OP_WRITE   = 2'd1;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_PRE    = 3'd2,
        ST_ACT    = 3'd3,
        ST_COL    = 3'd4,
        ST_DATA   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [63:0] dram_cycle_q, dram_cycle_d;
    logic [15:0] open_q, open_d;
    logic [14:0] open_row_q [16];
    logic [14:0] open_row_d [16];
    logic [63:0] act_ok_q [16];
    logic [63:0] act_ok_d [16];
    logic [63:0] col_ok_q [16];
    logic [63:0] col_ok_d [16];
    logic [63:0] pre_ok_q [16];
    logic [63:0] pre_ok_d [16];

    logic [1:0]  opcode_q, opcode_d;
    logic [1:0]  bg_q, bg_d;
    logic [1:0]  bank_q, bank_d;
    logic [14:0] row_q, row_d;
    logic [10:0] col_q, col_d;
    logic [1:0]  hit_q, hit_d;
    logic [63:0] issue_q, issue_d;

    logic        cmd_valid_q, cmd_valid_d;
    logic [2:0]  cmd_code_q, cmd_code_d;
    logic [1:0]  cmd_bg_q, cmd_bg_d;
    logic [1:0]  cmd_bank_q, cmd_bank_d;
    logic [14:0] cmd_row_q, cmd_row_d;
    logic [10:0] cmd_col_q, cmd_col_d;
    logic        req_done_q, req_done_d;
    logic [1:0]  hit_type_q, hit_type_d;

    // tick is the DRAM clock phase. Command outputs are registered, so the
    // issue decision is made one CPU clock early (phase_q=1) so that the
    // command becomes visible on the tick with dram_cycle equal to t.
    logic        tick;
    logic        issue_slot;
    logic [3:0]  bidx;
    logic [63:0] done_at;
    logic [63:0] rd_pre_ok;
    logic [63:0] wr_pre_ok;
    logic        unused_addr_bits;

    assign tick       = ~phase_q;
    assign issue_slot = phase_q;
    assign bidx       = {bg_q, bank_q};
    assign done_at    = issue_q + ((opcode_q == OP_WRITE) ? 64'(T_CWL + T_BURST)
                                                          : 64'(T_CL + T_BURST));
    assign rd_pre_ok  = dram_cycle_q + 64'(T_RTP);
    assign wr_pre_ok  = dram_cycle_q + 64'(T_CWL + T_BURST + T_WR);
    assign unused_addr_bits = ^req_addr[2:0];

    // Next-state, bank bookkeeping and command generation.
    always_comb begin
        phase_d      = ~phase_q;
        dram_cycle_d = dram_cycle_q + (tick ? 64'd1 : 64'd0);
        state_d      = state_q;
        open_d       = open_q;
        open_row_d   = open_row_q;
        act_ok_d     = act_ok_q;
        col_ok_d     = col_ok_q;
        pre_ok_d     = pre_ok_q;
        opcode_d     = opcode_q;
        bg_d         = bg_q;
        bank_d       = bank_q;
        row_d        = row_q;
        col_d        = col_q;
        hit_d        = hit_q;
        issue_d      = issue_q;
        cmd_valid_d  = 1'b0;
        cmd_code_d   = CMD_NOP;
        cmd_bg_d     = 2'd0;
        cmd_bank_d   = 2'd0;
        cmd_row_d    = 15'd0;
        cmd_col_d    = 11'd0;
        req_done_d   = 1'b0;
        hit_type_d   = HT_HIT;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    opcode_d = req_opcode;
                    bg_d     = req_addr[7:6];
                    bank_d   = req_addr[9:8];
                    row_d    = req_addr[32:18];
                    col_d    = {req_addr[17:10], req_addr[5:3]};
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (opcode_q == OP_ILLEGAL) begin
                    req_done_d = 1'b1;
                    hit_type_d = HT_HIT;
                    state_d    = ST_IDLE;
                end else if (open_q[bidx] && (open_row_q[bidx] == row_q)) begin
                    hit_d   = HT_HIT;
                    state_d = ST_COL;
                end else if (!open_q[bidx]) begin
                    hit_d   = HT_MISS;
                    state_d = ST_ACT;
                end else begin
                    hit_d   = HT_CONFLICT;
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                if (issue_slot && (dram_cycle_q >= pre_ok_q[bidx])) begin
                    cmd_valid_d    = 1'b1;
                    cmd_code_d     = CMD_PRE;
                    cmd_bg_d       = bg_q;
                    cmd_bank_d     = bank_q;
                    act_ok_d[bidx] = dram_cycle_q + 64'(T_RP);
                    open_d[bidx]   = 1'b0;
                    state_d        = ST_ACT;
                end
            end
            ST_ACT: begin
                if (issue_slot && (dram_cycle_q >= act_ok_q[bidx])) begin
                    cmd_valid_d      = 1'b1;
                    cmd_code_d       = CMD_ACT;
                    cmd_bg_d         = bg_q;
                    cmd_bank_d       = bank_q;
                    cmd_row_d        = row_q;
                    col_ok_d[bidx]   = dram_cycle_q + 64'(T_RCD);
                    pre_ok_d[bidx]   = dram_cycle_q + 64'(T_RAS);
                    open_d[bidx]     = 1'b1;
                    open_row_d[bidx] = row_q;
                    state_d          = ST_COL;
                end
            end
            ST_COL: begin
                if (issue_slot && (dram_cycle_q >= col_ok_q[bidx])) begin
                    cmd_valid_d = 1'b1;
                    cmd_bg_d    = bg_q;
                    cmd_bank_d  = bank_q;
                    cmd_col_d   = col_q;
                    issue_d     = dram_cycle_q;
                    if (opcode_q == OP_WRITE) begin
                        cmd_code_d = CMD_WR;
                        if (wr_pre_ok > pre_ok_q[bidx]) pre_ok_d[bidx] = wr_pre_ok;
                    end else begin
                        cmd_code_d = CMD_RD;
                        if (rd_pre_ok > pre_ok_q[bidx]) pre_ok_d[bidx] = rd_pre_ok;
                    end
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (dram_cycle_q >= done_at) begin
                    req_done_d = 1'b1;
                    hit_type_d = hit_q;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any request.
    always_ff @(posedge CPU_clock) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            dram_cycle_q <= 64'd0;
            open_q       <= 16'd0;
            open_row_q   <= '{default: '0};
            act_ok_q     <= '{default: '0};
            col_ok_q     <= '{default: '0};
            pre_ok_q     <= '{default: '0};
            opcode_q     <= 2'd0;
            bg_q         <= 2'd0;
            bank_q       <= 2'd0;
            row_q        <= 15'd0;
            col_q        <= 11'd0;
            hit_q        <= HT_HIT;
            issue_q      <= 64'd0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= CMD_NOP;
            cmd_bg_q     <= 2'd0;
            cmd_bank_q   <= 2'd0;
            cmd_row_q    <= 15'd0;
            cmd_col_q    <= 11'd0;
            req_done_q   <= 1'b0;
            hit_type_q   <= HT_HIT;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            dram_cycle_q <= dram_cycle_d;
            open_q       <= open_d;
            open_row_q   <= open_row_d;
            act_ok_q     <= act_ok_d;
            col_ok_q     <= col_ok_d;
            pre_ok_q     <= pre_ok_d;
            opcode_q     <= opcode_d;
            bg_q         <= bg_d;
            bank_q       <= bank_d;
            row_q        <= row_d;
            col_q        <= col_d;
            hit_q        <= hit_d;
            issue_q      <= issue_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            cmd_bg_q     <= cmd_bg_d;
            cmd_bank_q   <= cmd_bank_d;
            cmd_row_q    <= cmd_row_d;
            cmd_col_q    <= cmd_col_d;
            req_done_q   <= req_done_d;
            hit_type_q   <= hit_type_d;
        end
    end

    // Ready is held low during the req_done pulse so a new request never
    // overlaps the completion of the previous one.
    assign req_ready  = (state_q == ST_IDLE) && !req_done_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign cmd_bg     = cmd_bg_q;
    assign cmd_bank   = cmd_bank_q;
    assign cmd_row    = cmd_row_q;
    assign cmd_col    = cmd_col_q;
    assign dram_cycle = dram_cycle_q;
    assign req_done   = req_done_q;
    assign hit_type   = hit_type_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dram_cmd_sched
//  Purpose  : Self-checking bench for dram_cmd_sched: directed table, reset
//             corner case and randomized requests against a timing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dram_cmd_sched;
    logic        CPU_clock = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_opcode;
    logic [32:0] req_addr;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [14:0] cmd_row;
    logic [10:0] cmd_col;
    logic [63:0] dram_cycle;
    logic        req_done;
    logic [1:0]  hit_type;

    always #5 CPU_clock = ~CPU_clock;

    dram_cmd_sched dut (
        .CPU_clock (CPU_clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .req_addr  (req_addr),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_bg    (cmd_bg),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .dram_cycle(dram_cycle),
        .req_done  (req_done),
        .hit_type  (hit_type)
    );

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;

    // ---------------- reference model (DRAM-cycle arithmetic) ----------------
    typedef struct {
        longint      c;
        logic [2:0]  code;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [14:0] row;
        logic [10:0] col;
    } cmd_t;

    bit          m_open   [16];
    logic [14:0] m_row    [16];
    longint      m_act_ok [16];
    longint      m_col_ok [16];
    longint      m_pre_ok [16];
    cmd_t        exp_q[$];
    longint      exp_done;
    logic [1:0]  exp_hit;

    // CPU cycle n after reset: tick on even n, dram_cycle = (n+1)/2
    function automatic longint dram_of(input longint n);
        return (n + 1) / 2;
    endfunction

    // earliest tick cycle strictly after cycle 'after' whose dram_cycle >= ok
    function automatic longint slot(input longint after, input longint ok);
        longint c;
        c = after + 1;
        if (c % 2 != 0) c = c + 1;
        if (c < 2 * ok) c = 2 * ok;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 1'b0; m_row[i] = '0;
            m_act_ok[i] = 0; m_col_ok[i] = 0; m_pre_ok[i] = 0;
        end
    endtask

    task automatic model_req(input logic [1:0] op, input logic [32:0] a, input longint acc);
        logic [1:0]  bg, bk;
        logic [14:0] row;
        logic [10:0] col;
        int          b;
        longint      enter, c, t, tgt, x;
        bg = a[7:6]; bk = a[9:8]; row = a[32:18]; col = {a[17:10], a[5:3]};
        b = int'({bg, bk});
        exp_q.delete();
        if (op == 2'd3) begin
            exp_hit = 2'd0;
            exp_done = acc + 2;
            return;
        end
        if (m_open[b] && m_row[b] == row) exp_hit = 2'd0;
        else if (!m_open[b])              exp_hit = 2'd1;
        else                              exp_hit = 2'd2;
        enter = acc + 2;
        if (exp_hit == 2'd2) begin
            c = slot(enter, m_pre_ok[b]);
            exp_q.push_back('{c, 3'd4, bg, bk, 15'd0, 11'd0});
            m_act_ok[b] = c / 2 + 24;
            m_open[b] = 1'b0;
            enter = c;
        end
        if (exp_hit != 2'd0) begin
            c = slot(enter, m_act_ok[b]);
            exp_q.push_back('{c, 3'd1, bg, bk, row, 11'd0});
            m_col_ok[b] = c / 2 + 24;
            m_pre_ok[b] = c / 2 + 52;
            m_open[b] = 1'b1;
            m_row[b] = row;
            enter = c;
        end
        c = slot(enter, m_col_ok[b]);
        t = c / 2;
        exp_q.push_back('{c, (op == 2'd1) ? 3'd3 : 3'd2, bg, bk, 15'd0, col});
        if (op == 2'd1) begin
            if (t + 44 > m_pre_ok[b]) m_pre_ok[b] = t + 44;
            tgt = t + 24;
        end else begin
            if (t + 12 > m_pre_ok[b]) m_pre_ok[b] = t + 12;
            tgt = t + 28;
        end
        x = (c > 2 * tgt - 1) ? c : 2 * tgt - 1;
        exp_done = x + 1;
    endtask

    // ---------------- observation of the current request ----------------
    int          obs_n;
    logic [2:0]  obs_first;
    logic [1:0]  obs_bg, obs_bank, obs_hit;
    logic [10:0] obs_col;
    longint      obs_act, obs_pre, obs_colc, obs_done;
    bit          obs_has_act, obs_has_pre, obs_has_col;

    task automatic step();
        @(posedge CPU_clock);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_ge(input string name, input longint act, input longint req);
        vectors++;
        if (act < req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, req);
        end
    endtask

    task automatic check_cycle();
        cmd_t        e;
        logic        exp_v, exp_rdy, exp_dn;
        logic [63:0] exp_dram;
        bit          bad;
        e = '{0, 3'd0, 2'd0, 2'd0, 15'd0, 11'd0};
        exp_v = 1'b0;
        if (exp_q.size() > 0) begin
            if (exp_q[0].c == cyc) begin
                e = exp_q.pop_front();
                exp_v = 1'b1;
            end
        end
        exp_rdy  = (cyc > exp_done);
        exp_dn   = (cyc == exp_done);
        exp_dram = 64'(dram_of(cyc));
        vectors++;
        bad = (cmd_valid !== exp_v) || (cmd_code !== e.code) || (cmd_bg !== e.bg) ||
              (cmd_bank !== e.bank) || (cmd_row !== e.row) || (cmd_col !== e.col) ||
              (req_done !== exp_dn) || (req_ready !== exp_rdy) || (dram_cycle !== exp_dram) ||
              (exp_dn && (hit_type !== exp_hit));
        if (bad) begin
            miscompares++;
            $display("FAIL cycle_check cyc=%0d got v=%0b code=%0d bg=%0d bank=%0d row=%0d col=%0d done=%0b hit=%0d rdy=%0b dram=%0d expected v=%0b code=%0d bg=%0d bank=%0d row=%0d col=%0d done=%0b hit=%0d rdy=%0b dram=%0d",
                     cyc, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col, req_done, hit_type, req_ready, dram_cycle,
                     exp_v, e.code, e.bg, e.bank, e.row, e.col, exp_dn, exp_hit, exp_rdy, exp_dram);
        end
        if (cmd_valid === 1'b1) begin
            obs_n++;
            if (obs_n == 1) obs_first = cmd_code;
            case (cmd_code)
                3'd1: begin obs_has_act = 1'b1; obs_act = longint'(dram_cycle); end
                3'd4: begin obs_has_pre = 1'b1; obs_pre = longint'(dram_cycle); end
                3'd2, 3'd3: begin
                    obs_has_col = 1'b1; obs_colc = longint'(dram_cycle);
                    obs_bg = cmd_bg; obs_bank = cmd_bank; obs_col = cmd_col;
                end
                default: ;
            endcase
        end
        if (req_done === 1'b1) begin
            obs_done = longint'(dram_cycle);
            obs_hit  = hit_type;
        end
    endtask

    // Issue one request and check every cycle until one cycle after req_done.
    task automatic run_req(input logic [1:0] op, input logic [32:0] a);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin step(); guard++; end
        if (req_ready !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL ready_wait: got req_ready=%0b, expected 1", req_ready);
            return;
        end
        obs_n = 0; obs_first = 3'd0; obs_hit = 2'd3; obs_bg = 2'd0; obs_bank = 2'd0; obs_col = 11'd0;
        obs_has_act = 1'b0; obs_has_pre = 1'b0; obs_has_col = 1'b0;
        obs_act = -1; obs_pre = -1; obs_colc = -1; obs_done = -1;
        model_req(op, a, cyc);
        req_valid = 1'b1; req_opcode = op; req_addr = a;
        step();
        req_valid = 1'b0; req_opcode = 2'd0; req_addr = 33'd0;
        forever begin
            check_cycle();
            if (cyc >= exp_done + 1) break;
            step();
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [32:0] addr;
        logic [1:0]  hit;
        int          ncmd;
        logic [2:0]  first;
        logic [1:0]  bg;
        logic [1:0]  bank;
        logic [10:0] col;
        int          done_gap;   // req_done dram_cycle minus RD/WR dram_cycle
        int          pre_ref;    // 0 none, 1 previous ACT, 2 previous RD/WR
        int          pre_gap;
    } vec_t;

    localparam int NV = 10;
    vec_t   vt [NV];
    longint last_act, last_col;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rop;
        logic [32:0] ra;
        int          k;
        vt[0] = '{2'd0, 33'h0,       2'd1, 2, 3'd1, 2'd0, 2'd0, 11'd0, 28, 0, 0};
        vt[1] = '{2'd0, 33'h40000,   2'd2, 3, 3'd4, 2'd0, 2'd0, 11'd0, 28, 1, 52};
        vt[2] = '{2'd0, 33'h40400,   2'd0, 1, 3'd2, 2'd0, 2'd0, 11'd8, 28, 0, 0};
        vt[3] = '{2'd1, 33'h100,     2'd1, 2, 3'd1, 2'd0, 2'd1, 11'd0, 24, 0, 0};
        vt[4] = '{2'd0, 33'h40100,   2'd2, 3, 3'd4, 2'd0, 2'd1, 11'd0, 28, 2, 44};
        vt[5] = '{2'd0, 33'h40,      2'd1, 2, 3'd1, 2'd1, 2'd0, 11'd0, 28, 0, 0};
        vt[6] = '{2'd1, 33'h1402D8,  2'd1, 2, 3'd1, 2'd3, 2'd2, 11'd3, 24, 0, 0};
        vt[7] = '{2'd2, 33'h40008,   2'd0, 1, 3'd2, 2'd0, 2'd0, 11'd1, 28, 0, 0};
        vt[8] = '{2'd3, 33'h0,       2'd0, 0, 3'd0, 2'd0, 2'd0, 11'd0, 0,  0, 0};
        vt[9] = '{2'd0, 33'h0,       2'd2, 3, 3'd4, 2'd0, 2'd0, 11'd0, 28, 0, 0};

        rst_n = 1'b0; req_valid = 1'b0; req_opcode = 2'd0; req_addr = 33'd0;
        model_reset();
        @(posedge CPU_clock); @(posedge CPU_clock); #1;
        cyc = 0;
        vectors++;
        if ({req_ready, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col, req_done, hit_type} !==
            {1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 15'd0, 11'd0, 1'b0, 2'd0} || dram_cycle !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rdy=%0b v=%0b code=%0d done=%0b hit=%0d dram=%0d, expected rdy=1 v=0 code=0 done=0 hit=0 dram=0",
                     req_ready, cmd_valid, cmd_code, req_done, hit_type, dram_cycle);
        end
        rst_n = 1'b1;

        last_act = -1; last_col = -1;
        for (int i = 0; i < NV; i++) begin
            run_req(vt[i].op, vt[i].addr);
            chk($sformatf("v%0d_hit", i), longint'(obs_hit), longint'(vt[i].hit));
            chk($sformatf("v%0d_ncmd", i), longint'(obs_n), longint'(vt[i].ncmd));
            chk($sformatf("v%0d_first", i), longint'(obs_first), longint'(vt[i].first));
            if (vt[i].ncmd > 0) begin
                chk($sformatf("v%0d_colfields", i), longint'({obs_bg, obs_bank, obs_col}),
                    longint'({vt[i].bg, vt[i].bank, vt[i].col}));
                chk($sformatf("v%0d_done_gap", i), obs_done - obs_colc, longint'(vt[i].done_gap));
                if (obs_has_act) chk($sformatf("v%0d_act_to_col", i), obs_colc - obs_act, 24);
                if (obs_has_pre) chk($sformatf("v%0d_pre_to_act", i), obs_act - obs_pre, 24);
            end
            if (vt[i].pre_ref == 1) chk_ge($sformatf("v%0d_pre_after_act", i), obs_pre - last_act, longint'(vt[i].pre_gap));
            if (vt[i].pre_ref == 2) chk_ge($sformatf("v%0d_pre_after_wr", i), obs_pre - last_col, longint'(vt[i].pre_gap));
            if (obs_has_act) last_act = obs_act;
            if (obs_has_col) last_col = obs_colc;
        end

        // Reset while the ACT of a conflicting access is still waiting on tRP.
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin step(); k++; end
        req_valid = 1'b1; req_opcode = 2'd0; req_addr = 33'h80000;
        step();
        req_valid = 1'b0; req_addr = 33'd0;
        k = 0;
        while (!(cmd_valid === 1'b1 && cmd_code === 3'd4) && k < 400) begin step(); k++; end
        chk("mid_reset_pre_seen", longint'(k < 400), 1);
        repeat (6) step();
        rst_n = 1'b0;
        step();
        cyc = 0;
        chk("mid_reset_cmd_valid", longint'(cmd_valid), 0);
        chk("mid_reset_ready", longint'(req_ready), 1);
        chk("mid_reset_dram", longint'(dram_cycle), 0);
        rst_n = 1'b1;
        model_reset();
        run_req(2'd0, 33'h80000);
        chk("post_reset_hit", longint'(obs_hit), 1);
        chk("post_reset_first", longint'(obs_first), 1);

        // Randomized traffic over a few banks and rows to mix hits/misses/conflicts.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            rop = (r == 0) ? 2'd3 : (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : 2'd2;
            ra = {15'($urandom_range(0, 2)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            repeat ($urandom_range(0, 2)) step();
            run_req(rop, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
